// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter:
// requester ids, lock states and outstanding entries.
package mem_port_arbiter_pkg;

  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD0,
    HOLD1
  } lock_state_t;

  typedef struct packed {
    logic id;
    logic drop;
  } ost_entry_t;

endpackage

// File: rtl/mem_port_arbiter_fifo.sv
// In-order record of accepted requests awaiting data_ok,
// with bulk drop-by-id for cancelled requesters.
module outstanding_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic       push_id,
  input  logic       pop,
  input  logic [1:0] cancel,
  output ost_entry_t head,
  output logic       full,
  output logic       empty,
  output logic [PW:0] count
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] id_q;
  logic [DEPTH-1:0] drop_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == (PW+1)'(DEPTH));
  assign do_pop = pop & ~empty;

  // A cancel arriving with the pop still kills the head response.
  assign head = '{
    id:   id_q[rd_ptr],
    drop: drop_q[rd_ptr] | cancel[id_q[rd_ptr]]
  };

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_q  <= '0;
      id_q   <= '0;
      drop_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && cancel[id_q[i]])
          drop_q[i] <= 1'b1;
      end
      if (do_pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      if (push) begin
        vld_q[wr_ptr]  <= 1'b1;
        id_q[wr_ptr]   <= push_id;
        drop_q[wr_ptr] <= cancel[push_id];
        wr_ptr         <= wr_ptr + PW'(1);
      end
      unique case ({push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one sram-like port between inst fetch and data access,
// holding grants until addr_ok and routing responses in order.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [1:0]    s_req,
  input  logic [1:0]    s_wr,
  input  logic [3:0]    s_size,
  input  logic [7:0]    s_wstrb,
  input  logic [2*AW-1:0] s_addr,
  input  logic [2*DW-1:0] s_wdata,
  input  logic [1:0]    s_cancel,
  output logic [1:0]    s_addr_ok,
  output logic [1:0]    s_data_ok,
  output logic [DW-1:0] s_rdata,
  output logic          m_req,
  output logic          m_wr,
  output logic [1:0]    m_size,
  output logic [3:0]    m_wstrb,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_addr_ok,
  input  logic          m_data_ok,
  input  logic [DW-1:0] m_rdata
);

  localparam int CW = $clog2(MAX_OUT);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  lock_state_t   lock, lock_nx;
  logic          winner;
  logic          hs;
  logic          starve_hit;
  logic          full, empty;
  logic          resp;
  logic [CW:0]   ost_count;
  logic [SW-1:0] starve_cnt;
  ost_entry_t    head;

  assign starve_hit = s_req[REQ_INST] &&
                      (starve_cnt == SW'(STARVE_LIMIT));

  always_comb begin
    winner  = REQ_INST;
    lock_nx = lock;
    m_req   = 1'b0;
    unique case (lock)
      IDLE: begin
        winner = s_req[REQ_DATA] && !starve_hit;
        m_req  = resetn & s_req[winner] & ~full;
        if (m_req && !m_addr_ok)
          lock_nx = winner ? HOLD1 : HOLD0;
      end
      HOLD0: begin
        winner = REQ_INST;
        m_req  = resetn & s_req[winner] & ~full;
        if (m_addr_ok) lock_nx = IDLE;
      end
      HOLD1: begin
        winner = REQ_DATA;
        m_req  = resetn & s_req[winner] & ~full;
        if (m_addr_ok) lock_nx = IDLE;
      end
      default: lock_nx = IDLE;
    endcase
  end

  assign hs        = m_req & m_addr_ok;
  assign s_addr_ok = {hs & winner, hs & ~winner};

  assign m_wr    = winner ? s_wr[1]          : s_wr[0];
  assign m_size  = winner ? s_size[3:2]      : s_size[1:0];
  assign m_wstrb = winner ? s_wstrb[7:4]     : s_wstrb[3:0];
  assign m_addr  = winner ? s_addr[2*AW-1:AW] : s_addr[AW-1:0];
  assign m_wdata = winner ? s_wdata[2*DW-1:DW] : s_wdata[DW-1:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock       <= IDLE;
      starve_cnt <= '0;
    end else begin
      lock <= lock_nx;
      if (hs && winner == REQ_DATA) begin
        if (s_req[REQ_INST] && starve_cnt != SW'(STARVE_LIMIT))
          starve_cnt <= starve_cnt + SW'(1);
      end else if (hs) begin
        starve_cnt <= '0;
      end
    end
  end

  outstanding_fifo #(
    .DEPTH (MAX_OUT)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (hs),
    .push_id (winner),
    .pop     (m_data_ok),
    .cancel  (s_cancel),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (ost_count)
  );

  assign resp      = resetn & m_data_ok & ~empty & ~head.drop;
  assign s_data_ok = {resp & head.id, resp & ~head.id};
  assign s_rdata   = m_rdata;

  a_resp_has_owner: assert property (
    @(posedge clk) disable iff (!resetn) m_data_ok |-> !empty
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed arbitration,
// hold, full, cancel, starvation and reset scenarios.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic [1:0]    s_req, s_wr, s_cancel;
  logic [3:0]    s_size;
  logic [7:0]    s_wstrb;
  logic [63:0]   s_addr, s_wdata;
  logic [1:0]    s_addr_ok, s_data_ok;
  logic [DW-1:0] s_rdata;
  logic          m_req, m_wr;
  logic [1:0]    m_size;
  logic [3:0]    m_wstrb;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_addr_ok, m_data_ok;
  logic [DW-1:0] m_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .resetn    (resetn),
    .s_req     (s_req),
    .s_wr      (s_wr),
    .s_size    (s_size),
    .s_wstrb   (s_wstrb),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_cancel  (s_cancel),
    .s_addr_ok (s_addr_ok),
    .s_data_ok (s_data_ok),
    .s_rdata   (s_rdata),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_size    (m_size),
    .m_wstrb   (m_wstrb),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_addr_ok (m_addr_ok),
    .m_data_ok (m_data_ok),
    .m_rdata   (m_rdata)
  );

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] dn_q[$];
  int            dn_credit = 0;
  logic [1:0]    deliver = 2'b11;
  int            checks = 0;
  int            failures = 0;

  function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request side: record each accepted read the requester still wants.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (m_req && m_addr_ok) dn_q.push_back(m_addr);
      for (int k = 0; k < 2; k++) begin
        if (s_addr_ok[k] && deliver[k])
          exp_q.push_back('{id: k[0],
            data: rd_of(k == 1 ? s_addr[63:32] : s_addr[31:0])});
      end
    end
  end

  // Response side: every delivered response must match the queue head.
  always @(negedge clk) begin
    if (resetn === 1'b1 && s_data_ok != 2'b00) begin
      chk("data_ok_onehot", 64'($onehot(s_data_ok)), 64'd1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_data_ok actual=%b required=00",
                 s_data_ok);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_id", 64'(s_data_ok[1]), 64'(e.id));
        chk("resp_rdata", 64'(s_rdata), 64'(e.data));
      end
    end
  end

  // Downstream memory: answers in order, one cycle or more after accept.
  initial begin
    m_data_ok = 1'b0;
    m_rdata   = '0;
    forever begin
      @(posedge clk);
      #2;
      if (resetn !== 1'b1) begin
        dn_q.delete();
        m_data_ok = 1'b0;
      end else begin
        if (m_data_ok) void'(dn_q.pop_front());
        m_data_ok = 1'b0;
        if (dn_credit > 0 && dn_q.size() > 0) begin
          m_data_ok = 1'b1;
          m_rdata   = rd_of(dn_q[0]);
          dn_credit--;
        end
      end
    end
  end

  task automatic drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && dn_q.size() == 0 && !m_data_ok) break;
      tick();
    end
    chk({name, "_scoreboard"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_count"}, 64'(dut.ost_count), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    s_req     = 2'b11;
    s_wr      = 2'b00;
    s_size    = {2'd2, 2'd0};
    s_wstrb   = 8'hff;
    s_addr    = {32'h2000_0010, 32'h1000_0000};
    s_wdata   = '0;
    s_cancel  = 2'b00;
    m_addr_ok = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_m_req", 64'(m_req), 64'd0);
    chk("rst_addr_ok", 64'(s_addr_ok), 64'd0);
    chk("rst_data_ok", 64'(s_data_ok), 64'd0);
    chk("rst_lock", 64'(dut.lock), 64'(IDLE));
    chk("rst_count", 64'(dut.ost_count), 64'd0);
    tick();
    resetn = 1'b1;
    s_req  = 2'b00;
    tick();

    // Simultaneous requests: data first, then inst.
    dn_credit = 1000;
    s_req     = 2'b11;
    @(negedge clk);
    chk("t1_grant_a", 64'(s_addr_ok), 64'b10);
    chk("t1_addr_a", 64'(m_addr), 64'h2000_0010);
    chk("t1_size_a", 64'(m_size), 64'd2);
    tick();
    s_req = 2'b01;
    @(negedge clk);
    chk("t1_grant_b", 64'(s_addr_ok), 64'b01);
    chk("t1_size_b", 64'(m_size), 64'd0);
    chk("t1_head_a", 64'(dut.head.id), 64'd1);
    tick();
    s_req = 2'b00;
    @(negedge clk);
    chk("t1_head_b", 64'(dut.head.id), 64'd0);
    tick();
    drain("t1");

    // Held data grant survives a rising inst request.
    s_addr    = {32'h2000_0020, 32'h1000_0010};
    m_addr_ok = 1'b0;
    s_req     = 2'b10;
    @(negedge clk);
    chk("t2_m_req", 64'(m_req), 64'd1);
    chk("t2_addr0", 64'(m_addr), 64'h2000_0020);
    tick();
    s_req = 2'b11;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t2_hold_addr", 64'(m_addr), 64'h2000_0020);
      chk("t2_hold_lock", 64'(dut.lock), 64'(HOLD1));
      chk("t2_hold_ok", 64'(s_addr_ok), 64'b00);
      tick();
    end
    m_addr_ok = 1'b1;
    @(negedge clk);
    chk("t2_accept_data", 64'(s_addr_ok), 64'b10);
    tick();
    s_req = 2'b01;
    @(negedge clk);
    chk("t2_accept_inst", 64'(s_addr_ok), 64'b01);
    chk("t2_inst_addr", 64'(m_addr), 64'h1000_0010);
    tick();
    s_req = 2'b00;
    drain("t2");

    // Outstanding limit.
    dn_credit = 0;
    s_req     = 2'b10;
    for (int i = 0; i < 4; i++) begin
      s_addr[63:32] = 32'h2000_0100 + 32'(i * 4);
      @(negedge clk);
      chk("t3_fill", 64'(s_addr_ok), 64'b10);
      tick();
    end
    s_addr[63:32] = 32'h2000_0110;
    @(negedge clk);
    chk("t3_full_m_req", 64'(m_req), 64'd0);
    chk("t3_full_count", 64'(dut.ost_count), 64'd4);
    tick();
    dn_credit = 1;
    @(negedge clk);
    chk("t3_pop_m_req", 64'(m_req), 64'd0);
    chk("t3_pop_data_ok", 64'(m_data_ok), 64'd1);
    tick();
    @(negedge clk);
    chk("t3_refill_m_req", 64'(m_req), 64'd1);
    chk("t3_refill_ok", 64'(s_addr_ok), 64'b10);
    tick();
    s_req = 2'b00;
    @(negedge clk);
    chk("t3_count_after", 64'(dut.ost_count), 64'd4);
    tick();
    dn_credit = 1000;
    drain("t3");

    // Cancel drops earlier and same-cycle inst reads, not later ones.
    dn_credit = 0;
    deliver   = 2'b10;
    s_req     = 2'b01;
    s_addr[31:0] = 32'h1000_0200;
    @(negedge clk);
    chk("t4_issue0", 64'(s_addr_ok), 64'b01);
    tick();
    s_addr[31:0] = 32'h1000_0204;
    @(negedge clk);
    chk("t4_issue1", 64'(s_addr_ok), 64'b01);
    tick();
    s_req    = 2'b00;
    s_cancel = 2'b01;
    tick();
    s_cancel = 2'b00;
    s_req    = 2'b01;
    s_addr[31:0] = 32'h1000_0208;
    s_cancel = 2'b01;
    @(negedge clk);
    chk("t4_issue_cancel", 64'(s_addr_ok), 64'b01);
    tick();
    s_cancel = 2'b00;
    deliver  = 2'b11;
    s_addr[31:0] = 32'h1000_020c;
    @(negedge clk);
    chk("t4_issue_live", 64'(s_addr_ok), 64'b01);
    tick();
    s_req     = 2'b00;
    dn_credit = 1000;
    drain("t4");

    // Starvation guard: four data grants, then inst.
    s_addr = {32'h2000_0300, 32'h1000_0300};
    s_req  = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_grant", 64'(s_addr_ok), (i % 5 == 4) ? 64'b01 : 64'b10);
      tick();
    end
    s_req = 2'b00;
    drain("t5");

    // Reset with transactions in flight.
    dn_credit = 0;
    s_req     = 2'b10;
    for (int i = 0; i < 3; i++) begin
      s_addr[63:32] = 32'h2000_0400 + 32'(i * 4);
      @(negedge clk);
      chk("t6_issue", 64'(s_addr_ok), 64'b10);
      tick();
    end
    resetn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t6_rst_m_req", 64'(m_req), 64'd0);
    tick();
    @(negedge clk);
    chk("t6_rst_count", 64'(dut.ost_count), 64'd0);
    chk("t6_rst_lock", 64'(dut.lock), 64'(IDLE));
    chk("t6_rst_addr_ok", 64'(s_addr_ok), 64'b00);
    tick();
    resetn        = 1'b1;
    dn_credit     = 1000;
    s_addr[63:32] = 32'h2000_0500;
    @(negedge clk);
    chk("t6_regrant", 64'(s_addr_ok), 64'b10);
    tick();
    s_req = 2'b00;
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
